// File: rtl/vdma_read_arbiter_rr.sv
// Round-robin N-channel read-request arbiter: latches the granted channel's command and
// routes ack/data_valid/done back to that channel. Optional watchdog via VDMA_RD_ARB_TIMEOUT_EN.
module vdma_read_arbiter_rr #(
  parameter int NUM_CH         = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int BURST_WIDTH    = 8,
  parameter int CH_IDX_W       = $clog2(NUM_CH),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             sys_clk_i,
  input  logic                             reset_i,
  input  logic [NUM_CH-1:0]                req_i,
  input  logic [NUM_CH-1:0]                ch_en_i,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] rstart_addr_i,
  input  logic [NUM_CH*BURST_WIDTH-1:0]    burst_size_i,
  input  logic                             ack_i,
  input  logic                             data_valid_i,
  input  logic                             done_i,
  output logic                             req_o,
  output logic [AXI_ADDR_WIDTH-1:0]        rstart_addr_o,
  output logic [BURST_WIDTH-1:0]           burst_size_o,
  output logic [NUM_CH-1:0]                ack_o,
  output logic [NUM_CH-1:0]                data_valid_o,
  output logic [NUM_CH-1:0]                done_o,
  output logic [CH_IDX_W-1:0]              grant_idx_o,
`ifdef VDMA_RD_ARB_TIMEOUT_EN
  output logic                             timeout_o,
`endif
  output logic                             busy_o
);

  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("vdma_read_arbiter_rr: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

  state_e                    state_q, state_d;
  logic [CH_IDX_W-1:0]       last_q, last_d;
  logic [CH_IDX_W-1:0]       grant_q, grant_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BURST_WIDTH-1:0]    burst_q, burst_d;
  logic                      req_q, req_d;

  logic [NUM_CH-1:0]         eligible;
  logic                      found;
  logic [CH_IDX_W-1:0]       pick;
  int                        c;

  // Search starts just after the last grant, wrapping, so each channel waits at most NUM_CH-1 grants.
  always_comb begin
    eligible = req_i & ch_en_i;
    found    = 1'b0;
    pick     = '0;
    c        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = int'(last_q) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && eligible[c]) begin
        found = 1'b1;
        pick  = CH_IDX_W'(c);
      end
    end
  end

`ifdef VDMA_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = REQ;
        grant_d = pick;
        last_d  = pick;
        addr_d  = rstart_addr_i[int'(pick)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        burst_d = burst_size_i[int'(pick)*BURST_WIDTH +: BURST_WIDTH];
      end
      REQ:     if (ack_i) state_d = done_i ? IDLE : XFER;
      XFER:    if (done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef VDMA_RD_ARB_TIMEOUT_EN
    to_d  = 1'b0;
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    // Watchdog only fires when the transaction would otherwise stay open this edge.
    if (state_q != IDLE && state_d != IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
`endif
    req_d = (state_d == REQ);
  end

  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      last_q  <= CH_IDX_W'(NUM_CH - 1);
      grant_q <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      req_q   <= 1'b0;
`ifdef VDMA_RD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      req_q   <= req_d;
`ifdef VDMA_RD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  logic [NUM_CH-1:0] sel;
  assign sel           = NUM_CH'(1) << grant_q;
  assign ack_o         = (state_q == REQ && ack_i) ? sel : '0;
  assign data_valid_o  = (state_q != IDLE && data_valid_i) ? sel : '0;
  assign done_o        = (state_q != IDLE && done_i) ? sel : '0;
  assign req_o         = req_q;
  assign rstart_addr_o = addr_q;
  assign burst_size_o  = burst_q;
  assign grant_idx_o   = grant_q;
  assign busy_o        = (state_q != IDLE);
`ifdef VDMA_RD_ARB_TIMEOUT_EN
  assign timeout_o     = to_q;
`endif

endmodule

// File: tb/tb_vdma_read_arbiter_rr.sv
// Bench for vdma_read_arbiter_rr: vector table, directed corner sequences, and a
// randomized run against a rule-level model of the arbiter.
module tb_vdma_read_arbiter_rr;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, en;
  logic [N*AW-1:0] addr_flat;
  logic [N*BW-1:0] burst_flat;
  logic            ack, dv, done;
  logic            req_o, busy_o;
  logic [AW-1:0]   addr_o;
  logic [BW-1:0]   burst_o;
  logic [N-1:0]    ack_o, dv_o, done_o;
  logic [2:0]      gidx_o;
`ifdef VDMA_RD_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  always #5 clk = ~clk;

  vdma_read_arbiter_rr #(.NUM_CH(N), .AXI_ADDR_WIDTH(AW), .BURST_WIDTH(BW), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk_i(clk), .reset_i(rst_n), .req_i(req), .ch_en_i(en),
    .rstart_addr_i(addr_flat), .burst_size_i(burst_flat),
    .ack_i(ack), .data_valid_i(dv), .done_i(done),
    .req_o(req_o), .rstart_addr_o(addr_o), .burst_size_o(burst_o),
    .ack_o(ack_o), .data_valid_o(dv_o), .done_o(done_o), .grant_idx_o(gidx_o),
`ifdef VDMA_RD_ARB_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .busy_o(busy_o));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [AW-1:0] ch_addr(int k);
    return 32'h1000_0000 + AW'(k << 12);
  endfunction
  function automatic logic [BW-1:0] ch_burst(int k);
    return BW'(16 + k);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req = '0; en = '1; ack = 0; dv = 0; done = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic [N-1:0] req, en;
    logic         ack, dv, done;
    logic         e_req, e_busy;
    int           e_gidx;
    logic [N-1:0] e_ack, e_dv, e_done;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] e, logic a, logic d, logic dn,
                              logic er, logic eb, int eg, logic [N-1:0] ea, logic [N-1:0] ed,
                              logic [N-1:0] edn);
    vec_t v;
    v.req = r; v.en = e; v.ack = a; v.dv = d; v.done = dn;
    v.e_req = er; v.e_busy = eb; v.e_gidx = eg; v.e_ack = ea; v.e_dv = ed; v.e_done = edn;
    return v;
  endfunction

  // model state for the randomized run
  int           m_phase, m_last, m_g, m_tcnt, elig_c;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_burst;
  logic         m_to, m_to_next;
  logic [N-1:0] elig, m_sel;

  initial begin
    vec_t tv[15];
    int   cnt_dv, bad_dv, waited;

    for (int k = 0; k < N; k++) begin
      addr_flat[k*AW +: AW]  = ch_addr(k);
      burst_flat[k*BW +: BW] = ch_burst(k);
    end

    tv[0]  = mk(8'h01, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tv[1]  = mk(8'h00, 8'hFF, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    tv[2]  = mk(8'h00, 8'hFF, 1, 0, 0, 1, 1, 0, 8'h01, 8'h00, 8'h00);
    tv[3]  = mk(8'h00, 8'hFF, 0, 1, 0, 0, 1, 0, 8'h00, 8'h01, 8'h00);
    tv[4]  = mk(8'h00, 8'hFF, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h01);
    tv[5]  = mk(8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tv[6]  = mk(8'h00, 8'hFF, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tv[7]  = mk(8'h04, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tv[8]  = mk(8'h00, 8'hFF, 1, 0, 1, 1, 1, 2, 8'h04, 8'h00, 8'h04);
    tv[9]  = mk(8'h00, 8'hFF, 0, 0, 0, 0, 0, 2, 8'h00, 8'h00, 8'h00);
    tv[10] = mk(8'h05, 8'hFB, 0, 0, 0, 0, 0, 2, 8'h00, 8'h00, 8'h00);
    tv[11] = mk(8'h05, 8'hFB, 1, 0, 1, 1, 1, 0, 8'h01, 8'h00, 8'h01);
    tv[12] = mk(8'h05, 8'hFB, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tv[13] = mk(8'h05, 8'hFB, 1, 0, 1, 1, 1, 0, 8'h01, 8'h00, 8'h01);
    tv[14] = mk(8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

    // reset state
    req = '0; en = '1; ack = 0; dv = 0; done = 0; rst_n = 0;
    #2;
    check("reset_outputs", {req_o, busy_o, gidx_o, addr_o, burst_o, ack_o, dv_o, done_o}, '0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req = tv[i].req; en = tv[i].en; ack = tv[i].ack; dv = tv[i].dv; done = tv[i].done;
      #1;
      check($sformatf("vec%0d", i), {req_o, busy_o, gidx_o, ack_o, dv_o, done_o},
            {tv[i].e_req, tv[i].e_busy, 3'(tv[i].e_gidx), tv[i].e_ack, tv[i].e_dv, tv[i].e_done});
      if (tv[i].e_busy)
        check($sformatf("vec%0d_cmd", i), {addr_o, burst_o},
              {ch_addr(tv[i].e_gidx), ch_burst(tv[i].e_gidx)});
    end

    // strict round-robin with every channel requesting
    do_reset();
    @(negedge clk);
    req = '1; ack = 0; done = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rr_grant%0d", i), {req_o, gidx_o}, {1'b1, 3'(i % N)});
      ack = 1;
      @(negedge clk);
      ack = 0; done = 1;
      @(negedge clk);
      done = 0;
    end

    // data_valid routed only to channel 3 during XFER
    do_reset();
    req = 8'h08;
    @(negedge clk);
    req = '0; ack = 1;
    @(negedge clk);
    ack = 0;
    cnt_dv = 0; bad_dv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dv = (i % 2 == 0);
      #1;
      if (dv_o == 8'h08) cnt_dv++;
      if ((dv_o & 8'hF7) != 0 || req_o) bad_dv++;
    end
    dv = 0;
    check("dv_count", 128'(cnt_dv), 128'd4);
    check("dv_other_bits", 128'(bad_dv), 128'd0);
    @(negedge clk);
    done = 1;
    #1;
    check("xfer_done", {done_o, busy_o}, {8'h08, 1'b1});
    @(negedge clk);
    done = 0;
    #1;
    check("xfer_idle", 128'(busy_o), 128'd0);

    // asynchronous reset in the middle of a request
    req = 8'h01;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    check("midreset", {req_o, busy_o, gidx_o, addr_o, burst_o}, '0);
    @(negedge clk);
    rst_n = 1;
    req = 8'h03;
    @(negedge clk);
    #1;
    check("post_reset_grant", {req_o, gidx_o}, {1'b1, 3'd0});
    ack = 1; done = 1; req = '0;
    @(negedge clk);
    ack = 0; done = 0;

`ifdef VDMA_RD_ARB_TIMEOUT_EN
    do_reset();
    req = 8'h03;
    @(negedge clk);
    req = '0;
    #1;
    check("to_req_rose", 128'(req_o), 128'd1);
    waited = 0;
    while (waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
      if (timeout_o) break;
    end
    check("to_latency", 128'(waited), 128'(T));
    check("to_state", {busy_o, req_o, gidx_o, done_o}, {1'b0, 1'b0, 3'd0, 8'h00});
    @(negedge clk);
    #1;
    check("to_pulse_width", 128'(timeout_o), 128'd0);
    req = 8'h03;
    @(negedge clk);
    req = '0;
    #1;
    check("to_next_grant", {req_o, gidx_o}, {1'b1, 3'd1});
    ack = 1; done = 1;
    @(negedge clk);
    ack = 0; done = 0;
`else
    waited = 0;
`endif

    // randomized run against a rule-level model
    do_reset();
    m_phase = 0; m_last = N - 1; m_g = 0; m_tcnt = 0; m_addr = '0; m_burst = '0; m_to = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req  = N'($urandom);
      en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      ack  = ($urandom_range(0, 2) == 0);
      dv   = $urandom_range(0, 1) == 1;
      done = ($urandom_range(0, 3) == 0);
      #1;
      m_sel = N'(1) << m_g;
      check($sformatf("rand%0d", cyc),
            {req_o, busy_o, gidx_o, addr_o, burst_o, ack_o, dv_o, done_o},
            {m_phase == 1, m_phase != 0, 3'(m_g), m_addr, m_burst,
             (m_phase == 1 && ack) ? m_sel : 8'h00,
             (m_phase != 0 && dv) ? m_sel : 8'h00,
             (m_phase != 0 && done) ? m_sel : 8'h00});
`ifdef VDMA_RD_ARB_TIMEOUT_EN
      check($sformatf("rand%0d_to", cyc), 128'(timeout_o), 128'(m_to));
`endif
      m_to_next = 0;
      if (m_phase == 0) begin
        elig = req & en;
        if (elig != 0) begin
          for (int d = 1; d <= N; d++) begin
            elig_c = (m_last + d) % N;
            if (elig[elig_c]) begin
              m_g = elig_c;
              break;
            end
          end
          m_last = m_g; m_addr = ch_addr(m_g); m_burst = ch_burst(m_g);
          m_phase = 1; m_tcnt = 0;
        end
      end else begin
`ifdef VDMA_RD_ARB_TIMEOUT_EN
        if (!((m_phase == 1 && ack && done) || (m_phase == 2 && done)) && m_tcnt == T - 1) begin
          m_phase = 0; m_to_next = 1;
        end else
`endif
        if (m_phase == 1 && ack) m_phase = done ? 0 : 2;
        else if (m_phase == 2 && done) m_phase = 0;
        m_tcnt++;
      end
      m_to = m_to_next;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
